// File: rtl/rv_ifu_fetch.sv
// Instruction fetch stage: owns the PC, issues one word read per instruction and
// hands {pc, inst} to decode, honouring redirects, halt and stale-fetch discard.
module rv_ifu_fetch #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 imem_req_valid,
    input  logic                 imem_req_ready,
    output logic [WIDTH-1:0]     imem_req_addr,
    input  logic                 imem_rsp_valid,
    input  logic [WIDTH-1:0]     imem_rsp_data,
    input  logic                 imem_rsp_err,
    input  logic                 redirect_valid,
    input  logic [WIDTH-1:0]     redirect_pc,
    input  logic                 halt,
    output logic                 if_valid,
    input  logic                 if_ready,
    output logic [2*WIDTH-1:0]   IF_ID_message,
    output logic                 if_fault,
    output logic [31:0]          fetch_cnt
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   pc_q, pc_d;
    logic               drop_q, drop_d;
    logic [WIDTH-1:0]   hold_pc_q, hold_pc_d;
    logic [WIDTH-1:0]   hold_inst_q, hold_inst_d;
    logic               fault_q, fault_d;
    logic [31:0]        cnt_q, cnt_d;
    logic               req_fire;
    logic               if_fire;

    // Both valids are purely state-derived so neither handshake input feeds back combinationally.
    assign imem_req_valid = (state_q == S_REQ) & ~halt & rst;
    assign imem_req_addr  = pc_q;
    assign if_valid       = (state_q == S_HOLD) & rst;
    assign IF_ID_message  = {hold_pc_q, hold_inst_q};
    assign if_fault       = fault_q;
    assign fetch_cnt      = cnt_q;

    assign req_fire = imem_req_valid & imem_req_ready;
    assign if_fire  = if_valid & if_ready;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_d      = drop_q;
        hold_pc_d   = hold_pc_q;
        hold_inst_d = hold_inst_q;
        fault_d     = fault_q;
        cnt_d       = cnt_q;

        case (state_q)
            S_REQ: begin
                if (req_fire) begin
                    state_d = S_WAIT;
                    drop_d  = redirect_valid;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    drop_d = 1'b0;
                    if (drop_q | redirect_valid) begin
                        state_d = S_REQ;
                    end else begin
                        state_d     = S_HOLD;
                        hold_pc_d   = pc_q;
                        hold_inst_d = imem_rsp_err ? '0 : imem_rsp_data;
                        fault_d     = imem_rsp_err;
                    end
                end else if (redirect_valid) begin
                    drop_d = 1'b1;
                end
            end
            S_HOLD: begin
                // A redirect cancels the held instruction even if decode takes it this cycle.
                if (redirect_valid) begin
                    state_d = S_REQ;
                end else if (if_fire) begin
                    state_d = S_REQ;
                    pc_d    = pc_q + WIDTH'(4);
                    cnt_d   = cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

        if (redirect_valid) begin
            pc_d = {redirect_pc[WIDTH-1:2], 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            drop_q      <= 1'b0;
            hold_pc_q   <= '0;
            hold_inst_q <= '0;
            fault_q     <= 1'b0;
            cnt_q       <= 32'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_q      <= drop_d;
            hold_pc_q   <= hold_pc_d;
            hold_inst_q <= hold_inst_d;
            fault_q     <= fault_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: doc/rv_ifu_fetch.md
Name: rv_ifu_fetch

Overview:
- Instruction fetch stage, directly upstream of the decode stage.
- Holds the architectural PC and issues one word read per instruction on a valid/ready instruction-memory request channel.
- Captures the response and presents it to decode as IF_ID_message = {pc, inst} under a valid/ready handshake.
- Accepts PC redirects from branch/jump resolution, discards stale fetches, supports halt, and counts delivered instructions.

Parameters:
- WIDTH, 32, data/address width.
- RESET_PC, 32'h8000_0000, PC loaded on reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, active-low, synchronous: sampled on the rising edge of clk, active when 0.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  WIDTH  fetch address, equals current PC.
- imem_rsp_valid  input  1  read data valid; at most one response per accepted request; never in the same cycle as its request handshake.
- imem_rsp_data  input  WIDTH  instruction word.
- imem_rsp_err  input  1  access fault, qualified by imem_rsp_valid.
- redirect_valid  input  1  PC redirect request.
- redirect_pc  input  WIDTH  redirect target; bits [1:0] are ignored and forced to 0.
- halt  input  1  level; while 1, no new request is issued.
- if_valid  output  1  IF_ID_message valid.
- if_ready  input  1  decode accepts message.
- IF_ID_message  output  2*WIDTH  {pc, inst}, with pc in the upper half.
- if_fault  output  1  the held instruction came from an errored response; inst field is 0.
- fetch_cnt  output  32  number of delivered instructions; wraps modulo 2^32.

Behaviour:
- Reset (rst==0 at posedge):
  - pc=RESET_PC, state=S_REQ, drop=0, held pc/inst=0, if_fault=0, fetch_cnt=0.
  - imem_req_valid and if_valid are gated with rst, so both are 0 while rst==0.
  - Reset mid-transaction: the in-flight response is not tracked after reset; the memory side is reset together with this block.
- FSM states: S_REQ, S_WAIT, S_HOLD.
- S_REQ:
  - imem_req_valid = ~halt & rst; imem_req_addr = pc.
  - On handshake (valid & ready): go to S_WAIT.
  - halt rising while a request is pending and not accepted: the request is withdrawn. Valid may drop only because of halt or redirect.
- S_WAIT:
  - On imem_rsp_valid with drop==0: latch {pc, rsp_data}, or {pc, 0} with if_fault=1 when rsp_err; go to S_HOLD.
  - On imem_rsp_valid with drop==1: discard the data, clear drop, go to S_REQ.
- S_HOLD:
  - if_valid=1; IF_ID_message and if_fault stay stable until the handshake.
  - On if_valid & if_ready: pc<=pc+4 (mod 2^WIDTH, wraps at 32'hFFFF_FFFC -> 0), fetch_cnt+=1, go to S_REQ.
- Redirect (highest priority, any state, rst==1); pc<=redirect_pc & ~3 in every case:
  - S_REQ without handshake that cycle: stay in S_REQ; the next request uses the new pc.
  - S_REQ with handshake the same cycle: go to S_WAIT with drop=1.
  - S_WAIT without response: set drop=1, stay in S_WAIT.
  - S_WAIT with response the same cycle: discard it, go to S_REQ.
  - S_HOLD (with or without the if_ready handshake): the held instruction is discarded, fetch_cnt is not incremented, go to S_REQ; if_valid is 0 the next cycle.
  - Repeated redirects: the last one wins.
- halt does not affect S_WAIT or S_HOLD. An outstanding fetch completes and is delivered, and the pc advances; no further request is issued until halt==0.
- Latency:
  - Request issues in the cycle after entering S_REQ.
  - if_valid rises the cycle after imem_rsp_valid.
  - A new request follows the cycle after the if handshake.
  - Minimum 3 cycles per instruction with zero-wait memory.
- No combinational path from if_ready to imem_req_valid, or from imem_rsp_valid to if_valid.

Test Plan:
- Reset then zero-wait memory (ready=1, rsp one cycle later), if_ready=1: requests to 0x80000000, 0x80000004, 0x80000008, each 3 cycles apart; IF_ID_message = {addr, word}; fetch_cnt=3.
- Decode back-pressure: if_ready=0 for 5 cycles in S_HOLD. Message stays {0x80000000, 0x00100093}; no new request; after if_ready=1, next request addr=0x80000004.
- Redirect in S_WAIT to 0x80000103: the old response is dropped and if_valid stays 0; the next request addr is 0x80000100; fetch_cnt does not change for the dropped fetch.
- Redirect in the same cycle as the S_HOLD handshake, to 0x80000200: the instruction is not counted; the next addr is 0x80000200, not pc+4.
- Response with imem_rsp_err=1 at 0x80000010: if_fault=1, inst field 0, pc=0x80000010; delivered normally; fetch_cnt increments.
- halt=1 in S_REQ with ready=0: imem_req_valid drops to 0 and stays 0; reset with rst=0 mid-S_WAIT returns pc to 0x80000000 and both valids to 0; PC wrap: redirect to 0xFFFFFFFC then deliver -> next addr 0x00000000.
